// File: rtl/slow_bcd_counter.sv
// Edge-detects the divided SLOW level into a one-cycle tick and uses it to step
// a DIGITS-digit BCD up/down counter gated by an IDLE/RUN/PAUSE run control.
module slow_bcd_counter #(
    parameter int DIGITS = 4
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_slow,
    input  logic                  i_start,
    input  logic                  i_stop,
    input  logic                  i_clear,
    input  logic                  i_up,
    output logic [4*DIGITS-1:0]   o_count,
    output logic                  o_tick,
    output logic                  o_running,
    output logic                  o_wrap
);

    localparam int W = 4 * DIGITS;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic           r_slow_d;
    logic           r_tick;
    logic           r_running;
    logic           r_wrap;
    logic [W-1:0]   r_count;
    logic [W-1:0]   w_count_next;
    logic           w_carry;
    logic           w_step;

    assign w_step = r_tick && (r_state == ST_RUN) && !i_clear;

    // Run-control next state; CLEAR dominates, and START/STOP together resolve by current state.
    always_comb begin
        w_state_next = r_state;
        if (i_clear) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_PAUSE: begin
                    if (i_start) begin
                        w_state_next = ST_RUN;
                    end else begin
                        w_state_next = r_state;
                    end
                end
                ST_RUN: begin
                    if (i_stop) begin
                        w_state_next = ST_PAUSE;
                    end else begin
                        w_state_next = ST_RUN;
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    // Single-cycle BCD ripple: a carry/borrow surviving past the top digit is a wrap.
    always_comb begin
        w_count_next = r_count;
        w_carry      = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            if (w_carry) begin
                if (i_up) begin
                    if (r_count[4*d +: 4] == 4'd9) begin
                        w_count_next[4*d +: 4] = 4'd0;
                    end else begin
                        w_count_next[4*d +: 4] = r_count[4*d +: 4] + 4'd1;
                        w_carry                = 1'b0;
                    end
                end else begin
                    if (r_count[4*d +: 4] == 4'd0) begin
                        w_count_next[4*d +: 4] = 4'd9;
                    end else begin
                        w_count_next[4*d +: 4] = r_count[4*d +: 4] - 4'd1;
                        w_carry                = 1'b0;
                    end
                end
            end else begin
                w_count_next[4*d +: 4] = r_count[4*d +: 4];
            end
        end
    end

    // All state and registered outputs; the SLOW delay resets high so a level already high gives no tick.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_slow_d  <= 1'b1;
            r_tick    <= 1'b0;
            r_state   <= ST_IDLE;
            r_running <= 1'b0;
            r_count   <= '0;
            r_wrap    <= 1'b0;
        end else begin
            r_slow_d  <= i_slow;
            r_tick    <= i_slow & ~r_slow_d;
            r_state   <= w_state_next;
            r_running <= (w_state_next == ST_RUN);
            if (i_clear) begin
                r_count <= '0;
                r_wrap  <= 1'b0;
            end else if (w_step) begin
                r_count <= w_count_next;
                r_wrap  <= w_carry;
            end else begin
                r_count <= r_count;
                r_wrap  <= 1'b0;
            end
        end
    end

    assign o_count   = r_count;
    assign o_tick    = r_tick;
    assign o_running = r_running;
    assign o_wrap    = r_wrap;

endmodule

// File: tb/tb_slow_bcd_counter.sv
// Bench for slow_bcd_counter (DIGITS=4): directed table, corner sequences and
// random stimulus, all checked against an integer-valued reference model.
module tb_slow_bcd_counter;

    localparam int MOD = 10000;

    logic        clk;
    logic        i_reset, i_slow, i_start, i_stop, i_clear, i_up;
    logic [15:0] o_count;
    logic        o_tick, o_running, o_wrap;

    int n_vec = 0;
    int n_err = 0;

    // reference model: count as a plain integer modulo 10^4
    logic m_slow_d, m_tick, m_wrap;
    int   m_state;   // 0 idle, 1 run, 2 pause
    int   m_count;

    slow_bcd_counter #(.DIGITS(4)) dut (
        .i_clock  (clk),
        .i_reset  (i_reset),
        .i_slow   (i_slow),
        .i_start  (i_start),
        .i_stop   (i_stop),
        .i_clear  (i_clear),
        .i_up     (i_up),
        .o_count  (o_count),
        .o_tick   (o_tick),
        .o_running(o_running),
        .o_wrap   (o_wrap)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst, slow, start, stop, clear, up;
        logic [15:0] cnt;
        logic        tick, run, wrap;
    } vec_t;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int t;
        t = v;
        r = 16'd0;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        if (i_reset) begin
            m_slow_d = 1'b1;
            m_tick   = 1'b0;
            m_state  = 0;
            m_count  = 0;
            m_wrap   = 1'b0;
        end else begin
            if (i_clear) begin
                m_count = 0;
                m_wrap  = 1'b0;
            end else if (m_tick && m_state == 1) begin
                if (i_up) begin
                    m_wrap  = (m_count == MOD - 1);
                    m_count = (m_count + 1) % MOD;
                end else begin
                    m_wrap  = (m_count == 0);
                    m_count = (m_count + MOD - 1) % MOD;
                end
            end else begin
                m_wrap = 1'b0;
            end
            if (i_clear)                            m_state = 0;
            else if (m_state == 1 && i_stop)        m_state = 2;
            else if (m_state != 1 && i_start)       m_state = 1;
            m_tick   = i_slow & ~m_slow_d;
            m_slow_d = i_slow;
        end
    endtask

    task automatic cyc(input logic rst, input logic slow, input logic start,
                       input logic stop, input logic clear, input logic up);
        i_reset = rst; i_slow = slow; i_start = start;
        i_stop = stop; i_clear = clear; i_up = up;
        model_edge();
        @(posedge clk);
        #1;
        chk("model_count",   o_count,          to_bcd(m_count));
        chk("model_tick",    16'(o_tick),      16'(m_tick));
        chk("model_running", 16'(o_running),   16'(m_state == 1));
        chk("model_wrap",    16'(o_wrap),      16'(m_wrap));
    endtask

    task automatic do_tick(input logic up);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, up);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, up);
    endtask

    vec_t tbl[16];
    int   ticks_seen;
    logic prev_tick;

    initial begin
        i_reset = 1'b1; i_slow = 1'b1; i_start = 1'b0;
        i_stop = 1'b0; i_clear = 1'b0; i_up = 1'b1;
        m_slow_d = 1'b1; m_tick = 1'b0; m_state = 0; m_count = 0; m_wrap = 1'b0;

        // reset with SLOW already high: no tick for 20 cycles
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        ticks_seen = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
            if (o_tick) ticks_seen++;
        end
        chk("no_tick_after_reset", 16'(ticks_seen), 16'd0);
        chk("reset_count", o_count, 16'h0000);

        // directed table: inputs in the cycle, outputs after its closing edge
        tbl[0]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b1, 16'h0000, 1'b0,1'b0,1'b0};
        tbl[1]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b1, 16'h0000, 1'b0,1'b0,1'b0};
        tbl[2]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b1, 16'h0000, 1'b0,1'b1,1'b0};
        tbl[3]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b1, 16'h0000, 1'b1,1'b1,1'b0};
        tbl[4]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b1, 16'h0001, 1'b0,1'b1,1'b0};
        tbl[5]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 16'h0001, 1'b0,1'b1,1'b0};
        tbl[6]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b1, 16'h0001, 1'b1,1'b1,1'b0};
        tbl[7]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 16'h0000, 1'b0,1'b1,1'b0};
        tbl[8]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b1, 16'h0000, 1'b1,1'b1,1'b0};
        tbl[9]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 16'h9999, 1'b0,1'b1,1'b1};
        tbl[10] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 16'h9999, 1'b0,1'b1,1'b0};
        tbl[11] = '{1'b0,1'b1,1'b0,1'b1,1'b0,1'b1, 16'h9999, 1'b1,1'b0,1'b0};
        tbl[12] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b1, 16'h9999, 1'b0,1'b0,1'b0};
        tbl[13] = '{1'b0,1'b0,1'b1,1'b1,1'b0,1'b1, 16'h9999, 1'b0,1'b1,1'b0};
        tbl[14] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b1, 16'h9999, 1'b1,1'b1,1'b0};
        tbl[15] = '{1'b0,1'b1,1'b1,1'b0,1'b1,1'b1, 16'h0000, 1'b0,1'b0,1'b0};
        for (int i = 0; i < 16; i++) begin
            cyc(tbl[i].rst, tbl[i].slow, tbl[i].start, tbl[i].stop, tbl[i].clear, tbl[i].up);
            chk("tbl_count",   o_count,        tbl[i].cnt);
            chk("tbl_tick",    16'(o_tick),    16'(tbl[i].tick));
            chk("tbl_running", 16'(o_running), 16'(tbl[i].run));
            chk("tbl_wrap",    16'(o_wrap),    16'(tbl[i].wrap));
        end

        // 10 SLOW periods of 4 high / 4 low while running up
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("running_after_start", 16'(o_running), 16'd1);
        ticks_seen = 0;
        prev_tick  = 1'b0;
        for (int p = 0; p < 10; p++) begin
            for (int j = 0; j < 8; j++) begin
                cyc(1'b0, (j < 4) ? 1'b1 : 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
                if (o_tick) ticks_seen++;
                chk("tick_width", 16'(o_tick & prev_tick), 16'd0);
                prev_tick = o_tick;
                if (j == 0) chk("count_before_step", o_count, to_bcd(p));
                if (j == 1) chk("count_two_edges_after_rise", o_count, to_bcd(p + 1));
            end
        end
        chk("ten_ticks", 16'(ticks_seen), 16'd10);
        chk("count_0010", o_count, 16'h0010);

        // down-wrap from 0000 and up-wrap from 9999
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        do_tick(1'b0);
        chk("down_wrap_count", o_count, 16'h9999);
        chk("down_wrap_flag", 16'(o_wrap), 16'd1);
        do_tick(1'b0);
        chk("down_9998", o_count, 16'h9998);
        chk("down_9998_nowrap", 16'(o_wrap), 16'd0);
        do_tick(1'b1);
        do_tick(1'b1);
        chk("up_wrap_count", o_count, 16'h0000);
        chk("up_wrap_flag", 16'(o_wrap), 16'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("up_wrap_one_cycle", 16'(o_wrap), 16'd0);

        // digit carries without wrap
        for (int i = 0; i < 9; i++) do_tick(1'b1);
        chk("count_0009", o_count, 16'h0009);
        do_tick(1'b1);
        chk("count_0010_carry", o_count, 16'h0010);
        chk("carry_0010_nowrap", 16'(o_wrap), 16'd0);
        for (int i = 0; i < 89; i++) do_tick(1'b1);
        chk("count_0099", o_count, 16'h0099);
        do_tick(1'b1);
        chk("count_0100_carry", o_count, 16'h0100);
        chk("carry_0100_nowrap", 16'(o_wrap), 16'd0);

        // STOP coincident with TICK in RUN
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("stop_tick_count", o_count, 16'h0101);
        chk("stop_tick_paused", 16'(o_running), 16'd0);
        do_tick(1'b1);
        do_tick(1'b1);
        chk("pause_holds_count", o_count, 16'h0101);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("pause_start_stop_runs", 16'(o_running), 16'd1);

        // CLEAR with TICK and START at 0042, then RESET mid-run
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 42; i++) do_tick(1'b1);
        chk("count_0042", o_count, 16'h0042);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("clear_count", o_count, 16'h0000);
        chk("clear_idle", 16'(o_running), 16'd0);
        chk("clear_nowrap", 16'(o_wrap), 16'd0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        do_tick(1'b1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("reset_mid_count", o_count, 16'h0000);
        chk("reset_mid_tick", 16'(o_tick), 16'd0);
        chk("reset_mid_running", 16'(o_running), 16'd0);
        chk("reset_mid_wrap", 16'(o_wrap), 16'd0);

        // random stimulus against the model
        begin
            logic s;
            s = 1'b0;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 2) == 0) s = ~s;
                cyc(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0,
                    s,
                    ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0,
                    ($urandom_range(0, 11) == 0) ? 1'b1 : 1'b0,
                    ($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0,
                    ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
